dma_bus_arbiter: RTL and testbench

// Shares the AK6502 memory bus between the CPU and two DMA channels by cycle stealing.

---
 rtl/dma_bus_arbiter_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 19 +
 rtl/dma_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared definitions for the CPU/DMA cycle-stealing bus arbiter.
// Holds the FSM state encodings, the DMA beat record and a counter-width helper.
package dma_bus_arbiter_pkg;

    localparam logic [1:0] CPU_OWN = 2'd0;
    localparam logic [1:0] STALL   = 2'd1;
    localparam logic [1:0] DMA     = 2'd2;
    localparam logic [1:0] RECOVER = 2'd3;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
    } dma_beat_t;

    // Width needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to the channel
// that did not win last time. Purely combinational.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the memory bus between the CPU and two DMA channels by cycle stealing:
// the CPU is frozen through ready before a channel is granted, and gets a gap afterwards.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned CPU_GAP   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_o,
    input  logic        cpu_rw,
    input  logic        cpu_ph2,
    output logic        cpu_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    input  logic        dma0_req,
    input  logic [15:0] dma0_addr,
    input  logic        dma0_rw,
    input  logic [7:0]  dma0_wdata,
    output logic        dma0_ack,
    input  logic        dma1_req,
    input  logic [15:0] dma1_addr,
    input  logic        dma1_rw,
    input  logic [7:0]  dma1_wdata,
    output logic        dma1_ack,
    output logic [1:0]  dma_gnt,
    output logic [7:0]  dma_rdata
);

    localparam int unsigned BW = cnt_width(MAX_BURST);
    localparam int unsigned GW = cnt_width(CPU_GAP);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST);
    localparam logic [GW-1:0] GAP_INIT   = GW'(CPU_GAP);

    logic [1:0]    state_q, state_d;
    logic          ready_q, ready_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [BW-1:0] burst_q, burst_d, burst_nxt;
    logic [GW-1:0] gap_q, gap_d;
    logic          rr_last_q, rr_last_d;
    logic [7:0]    rdata_q, rdata_d;

    logic [1:0] req;
    logic [1:0] rr_gnt;
    logic       any_req;
    logic       gnt_req;
    logic       beat;
    dma_beat_t  sel;

    assign req     = {dma1_req, dma0_req};
    assign any_req = |req;
    assign gnt_req = |(gnt_q & req);
    assign beat    = (state_q == DMA) && gnt_req && clk_en;
    assign sel     = gnt_q[1] ? '{addr: dma1_addr, rw: dma1_rw, wdata: dma1_wdata}
                              : '{addr: dma0_addr, rw: dma0_rw, wdata: dma0_wdata};
    assign burst_nxt = burst_q + 1'b1;

    rr_arbiter2 u_rr (
        .req  (req),
        .last (rr_last_q),
        .gnt  (rr_gnt)
    );

    assign cpu_ready = ready_q;
    assign dma_gnt   = gnt_q;
    assign dma_rdata = rdata_q;
    assign dma0_ack  = beat && gnt_q[0];
    assign dma1_ack  = beat && gnt_q[1];

    always_comb begin
        if (state_q == DMA) begin
            mem_addr  = sel.addr;
            mem_wdata = sel.wdata;
            mem_we    = beat && !sel.rw;
        end else begin
            mem_addr  = cpu_address;
            mem_wdata = cpu_data_o;
            mem_we    = (state_q == CPU_OWN) && !cpu_rw && cpu_ph2 && ready_q && clk_en;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        gnt_d     = gnt_q;
        burst_d   = burst_q;
        gap_d     = gap_q;
        rr_last_d = rr_last_q;
        rdata_d   = rdata_q;
        case (state_q)
            CPU_OWN: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end
                if (any_req && gap_q == '0) begin
                    ready_d = 1'b0;
                    state_d = STALL;
                end
            end
            STALL: begin
                // Only hand over once the CPU has actually frozen on ph2.
                if (cpu_ph2 && any_req) begin
                    gnt_d     = rr_gnt;
                    rr_last_d = rr_gnt[1];
                    burst_d   = '0;
                    state_d   = DMA;
                end else if (!any_req) begin
                    state_d = RECOVER;
                end
            end
            DMA: begin
                if (gnt_req) begin
                    burst_d = burst_nxt;
                    if (sel.rw) begin
                        rdata_d = mem_rdata;
                    end
                    if (burst_nxt == BURST_LAST) begin
                        gnt_d   = 2'b00;
                        state_d = RECOVER;
                    end
                end else begin
                    gnt_d   = 2'b00;
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                gnt_d   = 2'b00;
                ready_d = 1'b1;
                gap_d   = GAP_INIT;
                state_d = CPU_OWN;
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CPU_OWN;
            ready_q   <= 1'b1;
            gnt_q     <= 2'b00;
            burst_q   <= '0;
            gap_q     <= '0;
            rr_last_q <= 1'b1;
            rdata_q   <= 8'h00;
        end else if (clk_en) begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            gnt_q     <= gnt_d;
            burst_q   <= burst_d;
            gap_q     <= gap_d;
            rr_last_q <= rr_last_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: a per-cycle vector table plus hand-built
// sequences for full bursts, clock-enable throttling and reset mid-burst.
module tb_dma_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst, clk_en;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data_o;
    logic        cpu_rw, cpu_ph2, cpu_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we;
    logic        dma0_req, dma0_rw, dma0_ack;
    logic [15:0] dma0_addr;
    logic [7:0]  dma0_wdata;
    logic        dma1_req, dma1_rw, dma1_ack;
    logic [15:0] dma1_addr;
    logic [7:0]  dma1_wdata;
    logic [1:0]  dma_gnt;
    logic [7:0]  dma_rdata;

    int n_vec;
    int n_bad;

    dma_bus_arbiter #(.MAX_BURST(8), .CPU_GAP(2)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .cpu_address(cpu_address), .cpu_data_o(cpu_data_o), .cpu_rw(cpu_rw),
        .cpu_ph2(cpu_ph2), .cpu_ready(cpu_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .dma0_req(dma0_req), .dma0_addr(dma0_addr), .dma0_rw(dma0_rw),
        .dma0_wdata(dma0_wdata), .dma0_ack(dma0_ack),
        .dma1_req(dma1_req), .dma1_addr(dma1_addr), .dma1_rw(dma1_rw),
        .dma1_wdata(dma1_wdata), .dma1_ack(dma1_ack),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata)
    );

    // Asynchronous memory: data is a fixed function of the address.
    assign mem_rdata = mem_addr[7:0] ^ 8'hA5;

    always #5 clk = ~clk;

    // in = {rst, en, ph2, cpu_rw, req0, req1, rw1}; ex = {ready, gnt[1:0], ack0, ack1, we}
    typedef struct packed {
        logic [6:0]  in;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [5:0]  ex;
        logic [15:0] ea;
        logic [7:0]  ewd;
        logic [7:0]  erd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [6:0] in, input logic [15:0] a0,
                                input logic [15:0] a1, input logic [5:0] ex,
                                input logic [15:0] ea, input logic [7:0] ewd,
                                input logic [7:0] erd);
        vec_t v;
        v = '{in: in, a0: a0, a1: a1, ex: ex, ea: ea, ewd: ewd, erd: erd};
        return v;
    endfunction

    function automatic logic [7:0] exp_rd(input int n);
        return (n == 0) ? 8'h00 : (8'(n - 1) ^ 8'hA5);
    endfunction

    task automatic drive(input logic [6:0] in, input logic [15:0] a0, input logic [15:0] a1,
                         input logic rw0);
        {rst, clk_en, cpu_ph2, cpu_rw, dma0_req, dma1_req, dma1_rw} = in;
        dma0_addr = a0;
        dma1_addr = a1;
        dma0_rw   = rw0;
    endtask

    task automatic check(input string name, input logic [5:0] ex, input logic [15:0] ea,
                         input logic [7:0] ewd, input logic [7:0] erd);
        logic [37:0] act, exp;
        act = {cpu_ready, dma_gnt, dma0_ack, dma1_ack, mem_we, mem_addr, mem_wdata, dma_rdata};
        exp = {ex, ea, ewd, erd};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got rdy/gnt/ack0/ack1/we=%b addr=%h wd=%h rd=%h, want %b %h %h %h",
                     name, act[37:32], act[31:16], act[15:8], act[7:0],
                     ex, ea, ewd, erd);
        end
    endtask

    task automatic check_count(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        drive(7'b1101001, 16'h0000, 16'h0000, 1'b1);
    endtask

    initial begin
        int beats;
        int acks;
        logic [5:0]  ex;
        logic [15:0] ea;
        logic [7:0]  ewd;
        logic        en;
        int          s;
        logic        eack;

        n_vec = 0;
        n_bad = 0;
        cpu_address = 16'h0200;
        cpu_data_o  = 8'h5A;
        dma0_wdata  = 8'h11;
        dma1_wdata  = 8'h22;
        drive(7'b1101001, 16'h0000, 16'h0000, 1'b1);

        // CPU traffic while idle
        vq.push_back(mk(7'b0100001, 16'h3000, 16'h0000, 6'b100000, 16'h0200, 8'h5A, 8'h00));
        vq.push_back(mk(7'b0110001, 16'h3000, 16'h0000, 6'b100001, 16'h0200, 8'h5A, 8'h00));
        vq.push_back(mk(7'b0101001, 16'h3000, 16'h0000, 6'b100000, 16'h0200, 8'h5A, 8'h00));
        vq.push_back(mk(7'b0111001, 16'h3000, 16'h0000, 6'b100000, 16'h0200, 8'h5A, 8'h00));
        // ch0: three reads then drop
        vq.push_back(mk(7'b0111101, 16'h3000, 16'h0000, 6'b100000, 16'h0200, 8'h5A, 8'h00));
        vq.push_back(mk(7'b0111101, 16'h3000, 16'h0000, 6'b000000, 16'h0200, 8'h5A, 8'h00));
        vq.push_back(mk(7'b0111101, 16'h3000, 16'h0000, 6'b001100, 16'h3000, 8'h11, 8'h00));
        vq.push_back(mk(7'b0111101, 16'h3001, 16'h0000, 6'b001100, 16'h3001, 8'h11, 8'hA5));
        vq.push_back(mk(7'b0111101, 16'h3002, 16'h0000, 6'b001100, 16'h3002, 8'h11, 8'hA4));
        vq.push_back(mk(7'b0111001, 16'h3003, 16'h0000, 6'b001000, 16'h3003, 8'h11, 8'hA7));
        vq.push_back(mk(7'b0111001, 16'h3003, 16'h0000, 6'b000000, 16'h0200, 8'h5A, 8'hA7));
        vq.push_back(mk(7'b1111001, 16'h3003, 16'h0000, 6'b100000, 16'h0200, 8'h5A, 8'hA7));
        // tie after reset -> ch0; STALL waits for ph2 and blocks CPU writes
        vq.push_back(mk(7'b0111110, 16'h4000, 16'h5000, 6'b100000, 16'h0200, 8'h5A, 8'h00));
        vq.push_back(mk(7'b0100110, 16'h4000, 16'h5000, 6'b000000, 16'h0200, 8'h5A, 8'h00));
        vq.push_back(mk(7'b0110110, 16'h4000, 16'h5000, 6'b000000, 16'h0200, 8'h5A, 8'h00));
        vq.push_back(mk(7'b0111110, 16'h4000, 16'h5000, 6'b001100, 16'h4000, 8'h11, 8'h00));
        vq.push_back(mk(7'b0111010, 16'h4001, 16'h5000, 6'b001000, 16'h4001, 8'h11, 8'hA5));
        vq.push_back(mk(7'b0111010, 16'h4001, 16'h5000, 6'b000000, 16'h0200, 8'h5A, 8'hA5));
        // gap of two, then ch1 write beat
        vq.push_back(mk(7'b0111010, 16'h4001, 16'h5000, 6'b100000, 16'h0200, 8'h5A, 8'hA5));
        vq.push_back(mk(7'b0111010, 16'h4001, 16'h5000, 6'b100000, 16'h0200, 8'h5A, 8'hA5));
        vq.push_back(mk(7'b0111010, 16'h4001, 16'h5000, 6'b100000, 16'h0200, 8'h5A, 8'hA5));
        vq.push_back(mk(7'b0111010, 16'h4001, 16'h5000, 6'b000000, 16'h0200, 8'h5A, 8'hA5));
        vq.push_back(mk(7'b0111010, 16'h4001, 16'h5000, 6'b010011, 16'h5000, 8'h22, 8'hA5));
        vq.push_back(mk(7'b0111000, 16'h4001, 16'h5001, 6'b010000, 16'h5001, 8'h22, 8'hA5));
        vq.push_back(mk(7'b0111000, 16'h4001, 16'h5001, 6'b000000, 16'h0200, 8'h5A, 8'hA5));
        // next tie -> ch0
        vq.push_back(mk(7'b0111110, 16'h4001, 16'h5001, 6'b100000, 16'h0200, 8'h5A, 8'hA5));
        vq.push_back(mk(7'b0111110, 16'h4001, 16'h5001, 6'b100000, 16'h0200, 8'h5A, 8'hA5));
        vq.push_back(mk(7'b0111110, 16'h4001, 16'h5001, 6'b100000, 16'h0200, 8'h5A, 8'hA5));
        vq.push_back(mk(7'b0111110, 16'h4001, 16'h5001, 6'b000000, 16'h0200, 8'h5A, 8'hA5));
        vq.push_back(mk(7'b0111110, 16'h4001, 16'h5001, 6'b001100, 16'h4001, 8'h11, 8'hA5));
        vq.push_back(mk(7'b0111000, 16'h4002, 16'h5001, 6'b001000, 16'h4002, 8'h11, 8'hA4));
        vq.push_back(mk(7'b0111000, 16'h4002, 16'h5001, 6'b000000, 16'h0200, 8'h5A, 8'hA4));
        // CPU write in gap; request withdrawn while stalled
        vq.push_back(mk(7'b0110000, 16'h4002, 16'h5001, 6'b100001, 16'h0200, 8'h5A, 8'hA4));
        vq.push_back(mk(7'b0111100, 16'h4002, 16'h5001, 6'b100000, 16'h0200, 8'h5A, 8'hA4));
        vq.push_back(mk(7'b0111100, 16'h4002, 16'h5001, 6'b100000, 16'h0200, 8'h5A, 8'hA4));
        vq.push_back(mk(7'b0101000, 16'h4002, 16'h5001, 6'b000000, 16'h0200, 8'h5A, 8'hA4));
        vq.push_back(mk(7'b0101000, 16'h4002, 16'h5001, 6'b000000, 16'h0200, 8'h5A, 8'hA4));
        vq.push_back(mk(7'b0101000, 16'h4002, 16'h5001, 6'b100000, 16'h0200, 8'h5A, 8'hA4));

        repeat (2) @(negedge clk);
        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].in, vq[i].a0, vq[i].a1, 1'b1);
            #2;
            check($sformatf("vec%0d", i), vq[i].ex, vq[i].ea, vq[i].ewd, vq[i].erd);
        end

        // ch1 held continuously: exactly MAX_BURST beats, recover, gap, re-stall
        reset_dut();
        beats = 0;
        acks  = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive(7'b0111011, 16'h0000, 16'h6000 + 16'(beats), 1'b1);
            #2;
            ea  = 16'h0200;
            ewd = 8'h5A;
            if (k == 0 || (k >= 11 && k <= 13)) begin
                ex = 6'b100000;
            end else if (k >= 2 && k <= 9) begin
                ex  = 6'b010010;
                ea  = 16'h6000 + 16'(beats);
                ewd = 8'h22;
            end else begin
                ex = 6'b000000;
            end
            check($sformatf("burst8_c%0d", k), ex, ea, ewd, exp_rd(beats));
            if (dma1_ack) acks++;
            if (ex[1]) beats++;
        end
        check_count("burst8_acks", acks, 8);

        // clk_en high one cycle in four during a full ch0 burst
        reset_dut();
        beats = 0;
        acks  = 0;
        for (int c = 0; c < 44; c++) begin
            en = (c % 4 == 0);
            s  = (c + 3) / 4;
            @(negedge clk);
            drive({1'b0, en, 5'b11101}, 16'h7000 + 16'(beats), 16'h0000, 1'b1);
            #2;
            eack = en && s >= 2 && s <= 9;
            if (s >= 2 && s <= 9) begin
                ex  = {3'b001, eack, 2'b00};
                ea  = 16'h7000 + 16'(beats);
                ewd = 8'h11;
            end else begin
                ex  = {(s == 0 || s >= 11), 5'b00000};
                ea  = 16'h0200;
                ewd = 8'h5A;
            end
            check($sformatf("clken_c%0d", c), ex, ea, ewd, exp_rd(beats));
            if (dma0_ack) acks++;
            if (eack) beats++;
        end
        check_count("clken_acks", acks, 8);

        // reset asserted on beat 4 of a ch0 burst
        reset_dut();
        beats = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            drive((c == 5) ? 7'b1111101 : 7'b0111101, 16'h8000 + 16'(beats), 16'h0000, 1'b1);
            #2;
            if (c >= 2 && c <= 5) begin
                check($sformatf("rstmid_c%0d", c), 6'b001100, 16'h8000 + 16'(beats), 8'h11,
                      exp_rd(beats));
                beats++;
            end else if (c == 1) begin
                check("rstmid_c1", 6'b000000, 16'h0200, 8'h5A, 8'h00);
            end else begin
                check($sformatf("rstmid_c%0d", c), 6'b100000, 16'h0200, 8'h5A, 8'h00);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
